// File: rtl/ppu_vram_arbiter.sv
// ppu_vram_arbiter: shares the single-port PPU memory bus between render fetches and CPU PPUDATA accesses
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   render_req/addr -> render_gnt render fetch request, granted combinationally
//   render_valid/render_data      fetched byte, one cycle after the grant
//   cpu_req/we/addr/wdata         CPU access, sampled while cpu_busy=0
//   cpu_busy/done/rdata           CPU access status and last read byte
//   mem_addr/data/rw, mem_q       memory wrapper pins (rw=1 write), 1-cycle read latency
module ppu_vram_arbiter #(
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        render_req,
    input  logic [13:0] render_addr,
    output logic        render_gnt,
    output logic        render_valid,
    output logic [7:0]  render_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [13:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_busy,
    output logic        cpu_done,
    output logic [7:0]  cpu_rdata,
    output logic [13:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_rw,
    input  logic [7:0]  mem_q
);
    typedef enum logic [1:0] {IDLE, PEND, ISSUED} state_t;
    state_t      state;
    logic        queued;
    logic        lat_we;
    logic [13:0] lat_addr;
    logic [7:0]  lat_wdata;
    logic [13:0] last_addr;
    logic [7:0]  last_data;
    logic [7:0]  rdata_q;
    logic [7:0]  wait_cnt;
    logic        cpu_issue;
    assign cpu_issue   = state == PEND && (!render_req || wait_cnt == 8'(MAX_WAIT));
    assign render_gnt  = rst_n && render_req && !cpu_issue;
    assign render_data = rst_n ? mem_q : 8'h00;
    assign mem_rw      = cpu_issue && lat_we;
    assign mem_addr    = render_gnt ? render_addr : cpu_issue ? lat_addr : last_addr;
    assign mem_data    = cpu_issue ? lat_wdata : last_data;
    // cpu_done is high exactly in the ISSUED cycle, when mem_q carries the CPU read byte
    assign cpu_rdata   = (cpu_done && !lat_we) ? mem_q : rdata_q;
    // A request taken in the ISSUED cycle waits one IDLE cycle (queued) so the
    // CPU path sustains one access every three cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            queued       <= 1'b0;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            last_addr    <= '0;
            last_data    <= '0;
            rdata_q      <= '0;
            wait_cnt     <= '0;
            cpu_busy     <= 1'b0;
            cpu_done     <= 1'b0;
            render_valid <= 1'b0;
        end else begin
            render_valid <= render_gnt;
            cpu_done     <= cpu_issue;
            if (render_gnt) last_addr <= render_addr;
            if (cpu_issue) begin
                last_addr <= lat_addr;
                last_data <= lat_wdata;
            end
            case (state)
                IDLE: begin
                    if (queued || cpu_req) begin
                        state    <= PEND;
                        cpu_busy <= 1'b1;
                        queued   <= 1'b0;
                        if (!queued) begin
                            lat_we    <= cpu_we;
                            lat_addr  <= cpu_addr;
                            lat_wdata <= cpu_wdata;
                        end
                    end
                end
                PEND: begin
                    if (cpu_issue) begin
                        state    <= ISSUED;
                        cpu_busy <= 1'b0;
                        wait_cnt <= '0;
                    end else if (wait_cnt != 8'(MAX_WAIT)) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ISSUED: begin
                    state <= IDLE;
                    if (!lat_we) rdata_q <= mem_q;
                    if (cpu_req) begin
                        lat_we    <= cpu_we;
                        lat_addr  <= cpu_addr;
                        lat_wdata <= cpu_wdata;
                        queued    <= 1'b1;
                        cpu_busy  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// tb_ppu_vram_arbiter: self-checking bench for ppu_vram_arbiter with a behavioural memory and reference model
module tb_ppu_vram_arbiter;
    localparam int MAX_WAIT = 8;
    logic        clk, rst_n;
    logic        render_req, render_gnt, render_valid;
    logic [13:0] render_addr;
    logic [7:0]  render_data;
    logic        cpu_req, cpu_we, cpu_busy, cpu_done;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic [13:0] mem_addr;
    logic [7:0]  mem_data, mem_q;
    logic        mem_rw;
    logic [7:0]  vram    [0:16383];
    logic [7:0]  ref_mem [0:16383];
    int vectors = 0;
    int miscompares = 0;

    ppu_vram_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .render_req(render_req), .render_addr(render_addr), .render_gnt(render_gnt),
        .render_valid(render_valid), .render_data(render_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_rw(mem_rw), .mem_q(mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial mem_q = 8'h00;
    always @(posedge clk) begin
        mem_q <= vram[mem_addr];
        if (mem_rw) vram[mem_addr] = mem_data;
    end

    task automatic idle(input int n);
        cpu_req = 1'b0;
        render_req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        render_req = 1'b0; render_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({render_gnt, render_valid, render_data, cpu_busy, cpu_done, cpu_rdata, mem_addr, mem_data, mem_rw} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got gnt=%b rv=%b rd=%h busy=%b done=%b rdata=%h addr=%h data=%h rw=%b, all 0 required",
                     render_gnt, render_valid, render_data, cpu_busy, cpu_done, cpu_rdata, mem_addr, mem_data, mem_rw);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if ({cpu_busy, cpu_done} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_release: got busy=%b done=%b, 0 0 required", cpu_busy, cpu_done);
        end
    endtask

    task automatic test_cpu_read;
        idle(2);
        vram[14'h2005] = 8'hA7;
        ref_mem[14'h2005] = 8'hA7;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2005; cpu_wdata = 8'h00;
        #1;
        vectors++;
        if (cpu_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_accept_busy: got %b, 0 required", cpu_busy);
        end
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        vectors++;
        if ({mem_addr, mem_rw, cpu_busy} !== {14'h2005, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL rd_issue: got addr=%h rw=%b busy=%b, addr=2005 rw=0 busy=1 required", mem_addr, mem_rw, cpu_busy);
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({cpu_done, cpu_busy, cpu_rdata} !== {1'b1, 1'b0, ref_mem[14'h2005]}) begin
            miscompares++;
            $display("FAIL rd_done: got done=%b busy=%b rdata=%h, 1 0 %h required", cpu_done, cpu_busy, cpu_rdata, ref_mem[14'h2005]);
        end
        repeat (2) begin
            @(negedge clk);
            #1;
            vectors++;
            if ({cpu_done, cpu_rdata} !== {1'b0, 8'hA7}) begin
                miscompares++;
                $display("FAIL rd_hold: got done=%b rdata=%h, 0 a7 required", cpu_done, cpu_rdata);
            end
        end
    endtask

    task automatic test_cpu_write;
        int wr_cycles = 0;
        idle(1);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h2400; cpu_wdata = 8'h3C;
        #1;
        if (mem_rw) wr_cycles++;
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        vectors++;
        if ({mem_rw, mem_addr, mem_data} !== {1'b1, 14'h2400, 8'h3C}) begin
            miscompares++;
            $display("FAIL wr_issue: got rw=%b addr=%h data=%h, 1 2400 3c required", mem_rw, mem_addr, mem_data);
        end
        ref_mem[14'h2400] = 8'h3C;
        if (mem_rw) wr_cycles++;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (mem_rw) wr_cycles++;
        end
        vectors++;
        if (wr_cycles != 1) begin
            miscompares++;
            $display("FAIL wr_pulse_len: got %0d write cycles, 1 required", wr_cycles);
        end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2400;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if ({cpu_done, cpu_rdata} !== {1'b1, ref_mem[14'h2400]}) begin
            miscompares++;
            $display("FAIL wr_readback: got done=%b rdata=%h, 1 %h required", cpu_done, cpu_rdata, ref_mem[14'h2400]);
        end
    endtask

    task automatic test_render_priority;
        int ri = 0, rx = 0, blk = 0, forced = 0, done_seen = 0;
        idle(2);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2003;
        render_req = 1'b1; render_addr = 14'h0000;
        for (int c = 0; c < 40 && (rx < 16 || done_seen == 0); c++) begin
            if (c > 0) begin
                @(negedge clk);
                cpu_req = 1'b0;
                render_req = ri < 16;
                render_addr = 14'(ri);
            end
            #1;
            if (render_valid) begin
                vectors++;
                if (render_data !== ref_mem[rx]) begin
                    miscompares++;
                    $display("FAIL prio_rdata[%0d]: got %h, %h required", rx, render_data, ref_mem[rx]);
                end
                rx++;
            end
            if (render_gnt) begin
                vectors++;
                if ({mem_addr, mem_rw} !== {render_addr, 1'b0}) begin
                    miscompares++;
                    $display("FAIL prio_gnt_bus: got addr=%h rw=%b, %h 0 required", mem_addr, mem_rw, render_addr);
                end
            end
            if (cpu_busy && render_gnt) blk++;
            if (cpu_busy && !render_gnt && render_req) begin
                forced++;
                vectors++;
                if ({mem_addr, mem_rw} !== {14'h2003, 1'b0} || blk != MAX_WAIT) begin
                    miscompares++;
                    $display("FAIL prio_forced: got addr=%h rw=%b after %0d blocked, 2003 0 after %0d required", mem_addr, mem_rw, blk, MAX_WAIT);
                end
            end
            if (cpu_done) begin
                done_seen++;
                vectors++;
                if (cpu_rdata !== ref_mem[14'h2003]) begin
                    miscompares++;
                    $display("FAIL prio_cpu_rdata: got %h, %h required", cpu_rdata, ref_mem[14'h2003]);
                end
            end
            if (render_gnt) ri++;
        end
        vectors++;
        if (rx != 16 || ri != 16 || forced != 1 || done_seen != 1 || blk != MAX_WAIT) begin
            miscompares++;
            $display("FAIL prio_summary: got fetched=%0d returned=%0d forced=%0d done=%0d blocked=%0d, 16 16 1 1 %0d required",
                     ri, rx, forced, done_seen, blk, MAX_WAIT);
        end
    endtask

    task automatic test_gap_service;
        int blk = 0;
        bit hit = 0;
        idle(2);
        render_req = 1'b1; render_addr = 14'h0100;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h2100; cpu_wdata = 8'h55;
        #1;
        vectors++;
        if (render_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL gap_gnt0: got %b, 1 required", render_gnt);
        end
        @(negedge clk);
        cpu_req = 1'b0; render_addr = 14'h0101;
        #1;
        vectors++;
        if ({render_gnt, cpu_busy, mem_rw} !== 3'b110) begin
            miscompares++;
            $display("FAIL gap_blocked: got gnt=%b busy=%b rw=%b, 1 1 0 required", render_gnt, cpu_busy, mem_rw);
        end
        @(negedge clk);
        render_req = 1'b0;
        #1;
        vectors++;
        if ({render_gnt, mem_rw, mem_addr, mem_data} !== {1'b0, 1'b1, 14'h2100, 8'h55}) begin
            miscompares++;
            $display("FAIL gap_issue: got gnt=%b rw=%b addr=%h data=%h, 0 1 2100 55 required", render_gnt, mem_rw, mem_addr, mem_data);
        end
        ref_mem[14'h2100] = 8'h55;
        @(negedge clk);
        render_req = 1'b1; render_addr = 14'h0102;
        #1;
        vectors++;
        if ({render_gnt, cpu_done, mem_addr, mem_rw} !== {1'b1, 1'b1, 14'h0102, 1'b0}) begin
            miscompares++;
            $display("FAIL gap_after: got gnt=%b done=%b addr=%h rw=%b, 1 1 0102 0 required", render_gnt, cpu_done, mem_addr, mem_rw);
        end
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2100; render_addr = 14'h0200;
        for (int c = 0; c < 20 && !hit; c++) begin
            if (c > 0) begin
                @(negedge clk);
                cpu_req = 1'b0;
            end
            #1;
            if (cpu_busy && render_gnt) blk++;
            else if (cpu_busy && !render_gnt) begin
                hit = 1;
                vectors++;
                if (blk != MAX_WAIT || mem_addr !== 14'h2100) begin
                    miscompares++;
                    $display("FAIL gap_wait_cleared: got %0d blocked addr=%h, %0d blocked addr=2100 required", blk, mem_addr, MAX_WAIT);
                end
            end
        end
        if (!hit) begin
            vectors++;
            miscompares++;
            $display("FAIL gap_timeout: got no CPU issue in 20 cycles, forced issue required");
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({cpu_done, cpu_rdata} !== {1'b1, 8'h55}) begin
            miscompares++;
            $display("FAIL gap_readback: got done=%b rdata=%h, 1 55 required", cpu_done, cpu_rdata);
        end
        render_req = 1'b0;
    endtask

    task automatic test_back_to_back;
        bit exp_done;
        idle(2);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            cpu_req = c < 8;
            cpu_we = 1'b0;
            cpu_addr = 14'h2000 + 14'(c < 2 ? 0 : c < 5 ? 1 : 2);
            #1;
            exp_done = c == 2 || c == 5 || c == 8;
            vectors++;
            if (cpu_done !== exp_done) begin
                miscompares++;
                $display("FAIL b2b_done[%0d]: got %b, %b required", c, cpu_done, exp_done);
            end
            if (exp_done) begin
                vectors++;
                if (cpu_rdata !== ref_mem[14'h2000 + 14'((c - 2) / 3)]) begin
                    miscompares++;
                    $display("FAIL b2b_rdata[%0d]: got %h, %h required", c, cpu_rdata, ref_mem[14'h2000 + 14'((c - 2) / 3)]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        idle(2);
        render_req = 1'b1; render_addr = 14'h0010;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2000;
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        vectors++;
        if (cpu_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_pend: got busy=%b, 1 required", cpu_busy);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({render_gnt, render_valid, render_data, cpu_busy, cpu_done, cpu_rdata, mem_addr, mem_data, mem_rw} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: got gnt=%b rv=%b rd=%h busy=%b done=%b rdata=%h addr=%h data=%h rw=%b, all 0 required",
                     render_gnt, render_valid, render_data, cpu_busy, cpu_done, cpu_rdata, mem_addr, mem_data, mem_rw);
        end
        @(negedge clk);
        render_req = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            vectors++;
            if ({cpu_busy, cpu_done, render_valid} !== 3'b000) begin
                miscompares++;
                $display("FAIL rstmid_after[%0d]: got busy=%b done=%b rv=%b, 0 0 0 required", c, cpu_busy, cpu_done, render_valid);
            end
        end
    endtask

    task automatic test_random;
        bit pend = 0, op_we = 0, dn_we = 0, gprev = 0;
        bit issue_now, exp_gnt, exp_busy, exp_done;
        int acc_t = 0, earliest = 0, blk = 0, issue_t = -10;
        logic [13:0] op_addr = '0, dn_addr = '0, last_addr = '0, gaddr = '0, exp_addr;
        logic [7:0] op_wd = '0, last_data = '0, exp_rdata = '0, exp_data;
        @(negedge clk);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            render_req = $urandom_range(0, 9) < 7;
            render_addr = 14'($urandom_range(0, 14'h1FFF));
            cpu_req = $urandom_range(0, 2) == 0;
            cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = 14'h2000 + 14'($urandom_range(0, 15));
            cpu_wdata = 8'($urandom);
            #1;
            // the CPU may use the bus once its earliest slot arrives, if render is absent or it has waited MAX_WAIT cycles
            issue_now = pend && t >= earliest && (!render_req || blk == MAX_WAIT);
            exp_gnt = render_req && !issue_now;
            exp_busy = pend && t > acc_t;
            exp_done = t == issue_t + 1;
            if (exp_done && !dn_we) exp_rdata = ref_mem[dn_addr];
            exp_addr = exp_gnt ? render_addr : issue_now ? op_addr : last_addr;
            exp_data = issue_now ? op_wd : last_data;
            vectors++;
            if ({render_gnt, mem_rw, cpu_busy, cpu_done} !== {exp_gnt, issue_now && op_we, exp_busy, exp_done}) begin
                miscompares++;
                $display("FAIL rnd_ctrl@%0d: got gnt=%b rw=%b busy=%b done=%b, %b %b %b %b required", t,
                         render_gnt, mem_rw, cpu_busy, cpu_done, exp_gnt, issue_now && op_we, exp_busy, exp_done);
            end
            vectors++;
            if (mem_addr !== exp_addr || mem_data !== exp_data) begin
                miscompares++;
                $display("FAIL rnd_bus@%0d: got addr=%h data=%h, %h %h required", t, mem_addr, mem_data, exp_addr, exp_data);
            end
            vectors++;
            if (render_valid !== gprev || (gprev && render_data !== ref_mem[gaddr])) begin
                miscompares++;
                $display("FAIL rnd_render@%0d: got rv=%b rd=%h, %b %h required", t, render_valid, render_data, gprev, ref_mem[gaddr]);
            end
            vectors++;
            if (cpu_rdata !== exp_rdata) begin
                miscompares++;
                $display("FAIL rnd_rdata@%0d: got %h, %h required", t, cpu_rdata, exp_rdata);
            end
            if (issue_now) begin
                pend = 0;
                issue_t = t;
                dn_we = op_we;
                dn_addr = op_addr;
                last_addr = op_addr;
                last_data = op_wd;
                if (op_we) ref_mem[op_addr] = op_wd;
            end else if (pend && t >= earliest && blk < MAX_WAIT) begin
                blk++;
            end
            if (exp_gnt) last_addr = render_addr;
            gprev = exp_gnt;
            gaddr = render_addr;
            if (cpu_req && !exp_busy) begin
                pend = 1;
                acc_t = t;
                earliest = exp_done ? t + 2 : t + 1;
                blk = 0;
                op_we = cpu_we;
                op_addr = cpu_addr;
                op_wd = cpu_wdata;
            end
        end
        idle(1);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            vram[i] = 8'($urandom);
            ref_mem[i] = vram[i];
        end
        test_reset;
        test_cpu_read;
        test_cpu_write;
        test_render_priority;
        test_gap_service;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ppu_vram_arbiter.md
Name: ppu_vram_arbiter

Overview:
- Shares the single-port PPU memory bus between two requesters: the PPU render fetch pipeline and the CPU-side PPUDATA ($2007) path. The bus covers CHR ROM at $0000-$1FFF and nametable VRAM at $2000-$3FFF.
- Sits directly in front of the PPU memory wrapper and drives its addr/data/rw pins; rw=1 is a write.
- Render fetches have priority. A wait counter guarantees a pending CPU access is served within a bounded number of cycles.
- Tracks the memory's fixed 1-cycle read latency and routes the returned byte to the requester that issued the read.

Parameters:
- MAX_WAIT, 8, number of consecutive cycles a pending CPU access may be blocked by render before it is forced onto the bus (range 1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- render_req  in  1  render fetch request; held high until granted
- render_addr  in  14  render fetch address
- render_gnt  out  1  combinational; render access issued to memory this cycle
- render_valid  out  1  registered; pulses the cycle after a render grant
- render_data  out  8  equals mem_q; meaningful when render_valid=1
- cpu_req  in  1  CPU access request; sampled only when cpu_busy=0
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  14  CPU access address
- cpu_wdata  in  8  CPU write data
- cpu_busy  out  1  pending or in-flight CPU access
- cpu_done  out  1  one-cycle pulse on completion
- cpu_rdata  out  8  last CPU read byte; held until the next CPU read completes
- mem_addr  out  14  to wrapper addr
- mem_data  out  8  to wrapper data
- mem_rw  out  1  to wrapper rw (1=write)
- mem_q  in  8  wrapper read data, valid the cycle after the address

Behaviour:
- Reset (async): all outputs 0; state IDLE; wait counter 0; pending request discarded.
- If reset is asserted mid-operation, no cpu_done is emitted and no render_valid is emitted for the in-flight fetch.
- CPU FSM states: IDLE, PEND, ISSUED.
  - IDLE: when cpu_req=1, latch cpu_we/cpu_addr/cpu_wdata and go to PEND; cpu_busy=1 from the next cycle.
  - PEND: issue when render_req=0, or when wait_cnt==MAX_WAIT (forced). While blocked, wait_cnt increments, saturating at MAX_WAIT. On issue: mem_addr=latched addr, mem_rw=latched we, mem_data=latched wdata, clear wait_cnt, go to ISSUED.
  - ISSUED (exactly one cycle): cpu_done=1. For a read, cpu_rdata<=mem_q in this cycle (visible next cycle) and the byte is also presented combinationally this cycle. cpu_busy=0 in this cycle. Return to IDLE.
- Timing:
  - A cpu_req seen in the ISSUED cycle is accepted, so back-to-back throughput is one access per 3 cycles.
  - No-contention latency: accept at T, issue at T+1, cpu_done at T+2.
- Render grant:
  - render_gnt = render_req AND NOT (state==PEND AND (forced OR render_req==0)). In effect render wins unless the CPU issue is forced.
  - On grant: mem_addr=render_addr, mem_rw=0.
  - render_valid=1 the following cycle, with render_data=mem_q.
  - A render request that is denied is not consumed; render_req stays high and is granted on the next non-forced cycle.
  - Render fetches are never writes.
- The render grant and the CPU issue never occur in the same cycle.
- Idle bus: mem_rw=0 and mem_addr/mem_data hold their last values. A write pulse is exactly one cycle.
- cpu_addr and render_addr pass through unmodified as 14 bits; no mirroring or palette decode in this block.
- A render grant may coincide with the ISSUED cycle: the CPU read data captured that cycle belongs to the CPU access, and the render data returns the next cycle.

Test Plan:
- Reset values: assert rst_n=0 mid-PEND → all outputs 0; after release cpu_busy=0, and no cpu_done ever appears for the dropped request.
- Uncontended CPU read: preload VRAM $2005=8'hA7; cpu_req, we=0, addr=14'h2005 at T → mem_addr=14'h2005 and mem_rw=0 at T+1; cpu_done and cpu_rdata=8'hA7 at T+2; cpu_rdata holds 8'hA7 afterwards.
- CPU write: we=1, addr=14'h2400, wdata=8'h3C → mem_rw=1 for exactly one cycle with mem_data=8'h3C; a subsequent CPU read of 14'h2400 returns 8'h3C.
- Render priority: render_req held continuously with addresses 14'h0000..14'h000F, plus a CPU read pending → render_gnt high for MAX_WAIT=8 cycles, then one forced CPU issue with render_gnt=0. render_valid data matches CHR bytes in order, with no fetch lost or duplicated.
- Gap service: render_req toggles 1,0,1 with a CPU write pending → the CPU issues in the render_req=0 cycle, wait_cnt resets to 0, and render_gnt is unaffected in the adjacent cycles.
- Back-to-back: cpu_req held high with reads of 14'h2000, 14'h2001, 14'h2002 → cpu_done every 3 cycles, and cpu_rdata sequence matches the preloaded VRAM values.
